// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for an async FIFO: binary + Gray write pointer,
// read-pointer synchronizer, full / fill level / sticky overflow. Optional FIFO_ALMOST_FULL_EN.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 4
`ifdef FIFO_ALMOST_FULL_EN
  ,parameter int AFULL_THRESH = 12
`endif
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH:0]   rd_gptr,
  input  logic                  ovf_clr,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_gptr,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
`ifdef FIFO_ALMOST_FULL_EN
  ,output logic                 almost_full
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] rq1_q, rq2_q, rq2_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          push;

  assign push = wr_req & ~full_q;

  // Gated by reset so the memory never sees a write while the block is held in reset.
  assign wr_en    = push & wr_rst_n;
  assign wr_addr  = wbin_q[ADDR_WIDTH-1:0];
  assign wr_gptr  = wgray_q;
  assign full     = full_q;
  assign wr_level = level_q;
  assign overflow = ovf_q;

  always_comb begin
    wbin_d  = wbin_q;
    if (push) wbin_d = wbin_q + PW'(1);
    wgray_d = bin2gray(wbin_d);
    // Flags use the value rq2 is about to take, so they track rq2 on the same edge.
    rq2_d   = rq1_q;
    full_d  = (wgray_d == {~rq2_d[PW-1:PW-2], rq2_d[PW-3:0]});
    level_d = wbin_d - gray2bin(rq2_d);
    ovf_d   = (wr_req & full_q) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      full_q  <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rd_gptr;
      rq2_q   <= rq2_d;
      full_q  <= full_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  logic afull_q, afull_d;

  assign afull_d     = (level_d >= PW'(AFULL_THRESH));
  assign almost_full = afull_q;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) afull_q <= 1'b0;
    else           afull_q <= afull_d;
  end
`endif

endmodule
